// File: rtl/sobel_pkg.sv
// Shared definitions for the sobel window generator.
//   PIX_W_DEFAULT : default pixel width in bits
//   W_TL..W_BR    : pixel slot indices inside a packed 3x3 window (TL in the MSBs)
//   win_pix()     : extracts one pixel of a default-width window by slot index
package sobel_pkg;

  localparam int unsigned PIX_W_DEFAULT = 8;

  localparam int unsigned W_TL = 8;
  localparam int unsigned W_TM = 7;
  localparam int unsigned W_TR = 6;
  localparam int unsigned W_ML = 5;
  localparam int unsigned W_MM = 4;
  localparam int unsigned W_MR = 3;
  localparam int unsigned W_BL = 2;
  localparam int unsigned W_BM = 1;
  localparam int unsigned W_BR = 0;

  function automatic logic [PIX_W_DEFAULT-1:0] win_pix(
    input logic [9*PIX_W_DEFAULT-1:0] window,
    input int unsigned                idx
  );
    return window[idx*PIX_W_DEFAULT +: PIX_W_DEFAULT];
  endfunction

endpackage

// File: rtl/sobel_window_gen_if.sv
// Stream bundle of the sobel window generator.
//   in_valid/in_ready/in_pixel           : raster-order pixel input
//   out_valid/out_ready/out_window       : 3x3 window output, {TL..BR}, TL in the MSBs
//   out_col/out_row                      : centre pixel coordinates of out_window
//   frame_done                           : 1-cycle pulse after the last pixel of a frame
//   out_last (SOBEL_WIN_LAST_EN only)    : marks the final window of a frame
// Modports: slave = the window generator, master = the pixel source / window sink.
interface sobel_window_gen_if #(
  parameter int unsigned PIX_W = 8,
  parameter int unsigned IMG_W = 640,
  parameter int unsigned IMG_H = 480,
  parameter int unsigned CW    = $clog2(IMG_W),
  parameter int unsigned RW    = $clog2(IMG_H)
) ();

  logic                 in_valid;
  logic                 in_ready;
  logic [PIX_W-1:0]     in_pixel;
  logic                 out_valid;
  logic                 out_ready;
  logic [9*PIX_W-1:0]   out_window;
  logic [CW-1:0]        out_col;
  logic [RW-1:0]        out_row;
  logic                 frame_done;
`ifdef SOBEL_WIN_LAST_EN
  logic                 out_last;
`endif

  modport slave (
    input  in_valid, in_pixel, out_ready,
    output in_ready, out_valid, out_window, out_col, out_row, frame_done
`ifdef SOBEL_WIN_LAST_EN
    , output out_last
`endif
  );

  modport master (
    output in_valid, in_pixel, out_ready,
    input  in_ready, out_valid, out_window, out_col, out_row, frame_done
`ifdef SOBEL_WIN_LAST_EN
    , input out_last
`endif
  );

endinterface

// File: rtl/sobel_window_gen_line_ram.sv
// One image row of pixel storage for the sobel window generator.
//   clk   : write clock
//   we    : write enable
//   addr  : column index, shared by read and write
//   wdata : pixel written at addr on the rising edge when we=1
//   rdata : combinational read of addr (returns the old value in the write cycle)
// Contents are not reset.
module sobel_line_ram #(
  parameter int unsigned PIX_W = 8,
  parameter int unsigned DEPTH = 640,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [PIX_W-1:0] wdata,
  output logic [PIX_W-1:0] rdata
);

  logic [PIX_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
  end

  always_comb begin
    rdata = mem_q[addr];
  end

endmodule

// File: rtl/sobel_window_gen.sv
// Sobel window generator: turns a raster-order pixel stream into 3x3 windows,
// one per interior pixel, using two line buffers and a 3x3 shift register.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : sobel_window_gen_if.slave (pixel input, window output, frame_done)
// Optional macro SOBEL_WIN_LAST_EN adds bus.out_last, high with the final window of a frame.
module sobel_window_gen
  import sobel_pkg::*;
#(
  parameter int unsigned PIX_W = PIX_W_DEFAULT,
  parameter int unsigned IMG_W = 640,
  parameter int unsigned IMG_H = 480,
  parameter int unsigned CW    = $clog2(IMG_W),
  parameter int unsigned RW    = $clog2(IMG_H)
) (
  input  logic               clk,
  input  logic               reset,
  sobel_window_gen_if.slave  bus
);

  logic [CW-1:0]             col_q, col_d;
  logic [RW-1:0]             row_q, row_d;
  logic [8:0][PIX_W-1:0]     win_q, win_d;
  logic                      out_valid_q, out_valid_d;
  logic [9*PIX_W-1:0]        out_window_q, out_window_d;
  logic [CW-1:0]             out_col_q, out_col_d;
  logic [RW-1:0]             out_row_q, out_row_d;
  logic                      frame_done_q, frame_done_d;
`ifdef SOBEL_WIN_LAST_EN
  logic                      out_last_q, out_last_d;
`endif

  logic [PIX_W-1:0]          top_pix, mid_pix;
  logic                      in_ready, accept, emit, col_last, row_last;

  // lb0 holds the previous row, lb1 the row before it; lb1 is refilled from lb0's read data.
  sobel_line_ram #(.PIX_W(PIX_W), .DEPTH(IMG_W), .AW(CW)) u_lb0 (
    .clk   (clk),
    .we    (accept),
    .addr  (col_q),
    .wdata (bus.in_pixel),
    .rdata (mid_pix)
  );

  sobel_line_ram #(.PIX_W(PIX_W), .DEPTH(IMG_W), .AW(CW)) u_lb1 (
    .clk   (clk),
    .we    (accept),
    .addr  (col_q),
    .wdata (mid_pix),
    .rdata (top_pix)
  );

  always_comb begin
    in_ready = !out_valid_q || bus.out_ready;
    accept   = bus.in_valid && in_ready;
    col_last = (col_q == CW'(IMG_W - 1));
    row_last = (row_q == RW'(IMG_H - 1));
    // Columns 0/1 and rows 0/1 would pull in wrapped or previous-frame pixels.
    emit     = accept && (row_q >= RW'(2)) && (col_q >= CW'(2));

    col_d        = col_q;
    row_d        = row_q;
    win_d        = win_q;
    out_valid_d  = out_valid_q;
    out_window_d = out_window_q;
    out_col_d    = out_col_q;
    out_row_d    = out_row_q;
    frame_done_d = accept && col_last && row_last;
`ifdef SOBEL_WIN_LAST_EN
    out_last_d   = out_last_q;
`endif

    if (accept) begin
      win_d[W_TL] = win_q[W_TM];
      win_d[W_TM] = win_q[W_TR];
      win_d[W_TR] = top_pix;
      win_d[W_ML] = win_q[W_MM];
      win_d[W_MM] = win_q[W_MR];
      win_d[W_MR] = mid_pix;
      win_d[W_BL] = win_q[W_BM];
      win_d[W_BM] = win_q[W_BR];
      win_d[W_BR] = bus.in_pixel;

      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end

    // accept implies the output register is free or draining this cycle.
    if (emit) begin
      out_valid_d  = 1'b1;
      out_window_d = win_d;
      out_col_d    = col_q - CW'(1);
      out_row_d    = row_q - RW'(1);
`ifdef SOBEL_WIN_LAST_EN
      out_last_d   = col_last && row_last;
`endif
    end else if (bus.out_ready) begin
      out_valid_d  = 1'b0;
`ifdef SOBEL_WIN_LAST_EN
      out_last_d   = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_q        <= '0;
      row_q        <= '0;
      win_q        <= '0;
      out_valid_q  <= 1'b0;
      out_window_q <= '0;
      out_col_q    <= '0;
      out_row_q    <= '0;
      frame_done_q <= 1'b0;
`ifdef SOBEL_WIN_LAST_EN
      out_last_q   <= 1'b0;
`endif
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      win_q        <= win_d;
      out_valid_q  <= out_valid_d;
      out_window_q <= out_window_d;
      out_col_q    <= out_col_d;
      out_row_q    <= out_row_d;
      frame_done_q <= frame_done_d;
`ifdef SOBEL_WIN_LAST_EN
      out_last_q   <= out_last_d;
`endif
    end
  end

  always_comb begin
    bus.in_ready   = in_ready;
    bus.out_valid  = out_valid_q;
    bus.out_window = out_window_q;
    bus.out_col    = out_col_q;
    bus.out_row    = out_row_q;
    bus.frame_done = frame_done_q;
`ifdef SOBEL_WIN_LAST_EN
    bus.out_last   = out_last_q;
`endif
  end

endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed bench for sobel_window_gen with an 8x6 image, pixel value = raster index + base.
module tb_sobel_window_gen;
  import sobel_pkg::*;

  localparam int unsigned PW = 8;
  localparam int unsigned W  = 8;
  localparam int unsigned H  = 6;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  sobel_window_gen_if #(.PIX_W(PW), .IMG_W(W), .IMG_H(H)) bus ();

  sobel_window_gen #(.PIX_W(PW), .IMG_W(W), .IMG_H(H)) dut (
    .clk   (clk),
    .reset (reset_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int fd_cnt = 0;
  logic [71:0] q_win [$];
  logic [7:0]  q_col [$];
  logic [7:0]  q_row [$];
  logic        q_last [$];

  // Record every window handed over (valid & ready seen away from the edge).
  always @(negedge clk) begin
    if (reset_n && bus.out_valid && bus.out_ready) begin
      q_win.push_back(bus.out_window);
      q_col.push_back(8'(bus.out_col));
      q_row.push_back(8'(bus.out_row));
`ifdef SOBEL_WIN_LAST_EN
      q_last.push_back(bus.out_last);
`else
      q_last.push_back(1'b0);
`endif
    end
    if (reset_n && bus.frame_done) fd_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] exp_win(input int k, input int base);
    int c;
    int r;
    logic [71:0] w;
    c = k % (int'(W) - 2) + 1;
    r = k / (int'(W) - 2) + 1;
    w = '0;
    for (int dy = 0; dy < 3; dy++)
      for (int dx = 0; dx < 3; dx++)
        w = {w[63:0], 8'(base + (r - 1 + dy) * int'(W) + (c - 1 + dx))};
    return w;
  endfunction

  task automatic send(input int v, input bit rnd);
    bit ok;
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_pixel = 8'(v);
    do begin
      if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 200);
    if (!ok) check("accept_timeout", 72'(ok), 72'(1));
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    q_win.delete();
    q_col.delete();
    q_row.delete();
    q_last.delete();
  endtask

  task automatic check_frame(input int start, input int base, input string tag);
    for (int k = 0; k < 24; k++) begin
      if (start + k < q_win.size()) begin
        check({tag, "_win"}, q_win[start + k], exp_win(k, base));
        check({tag, "_pos"}, 72'({q_col[start + k], q_row[start + k]}),
              72'({8'(k % 6 + 1), 8'(k / 6 + 1)}));
      end
    end
  endtask

  initial begin
    int fd0;
    logic [71:0] held;
    bus.in_valid  = 1'b0;
    bus.in_pixel  = '0;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid",  72'(bus.out_valid),  72'(0));
    check("rst_out_window", 72'(bus.out_window), 72'(0));
    check("rst_out_col",    72'(bus.out_col),    72'(0));
    check("rst_out_row",    72'(bus.out_row),    72'(0));
    check("rst_frame_done", 72'(bus.frame_done), 72'(0));
`ifdef SOBEL_WIN_LAST_EN
    check("rst_out_last",   72'(bus.out_last),   72'(0));
`endif
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", 72'(bus.in_ready), 72'(1));

    // One frame at full rate: first window latency, last window, frame_done
    for (int i = 0; i < 48; i++) begin
      send(i, 1'b0);
      if (i == 17) check("pre_first_valid", 72'(bus.out_valid), 72'(0));
      if (i == 18) begin
        check("first_valid",  72'(bus.out_valid), 72'(1));
        check("first_window", bus.out_window, 72'h000102_08090A_101112);
        check("first_col",    72'(bus.out_col), 72'(1));
        check("first_row",    72'(bus.out_row), 72'(1));
      end
      if (i == 46) check("fd_early", 72'(bus.frame_done), 72'(0));
      if (i == 47) check("fd_pulse", 72'(bus.frame_done), 72'(1));
    end
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("fd_one_cycle", 72'(bus.frame_done), 72'(0));
    drain();
    check("s1_count", 72'(q_win.size()), 72'(24));
    if (q_win.size() >= 24) begin
      check("s1_last_win", q_win[23], 72'h1D1E1F_252627_2D2E2F);
      check("s1_last_pos", 72'({q_col[23], q_row[23]}), 72'({8'd6, 8'd4}));
      check("s1_last_mm",  72'(win_pix(q_win[23], W_MM)), 72'(38));
    end
    check_frame(0, 0, "s1");
    check("s1_fd_count", 72'(fd_cnt), 72'(1));
`ifdef SOBEL_WIN_LAST_EN
    for (int k = 0; k < 24; k++)
      if (k < q_last.size()) check("s6_out_last", 72'(q_last[k]), 72'(k == 23));
`endif

    // Random backpressure with a 5-cycle hold
    clear_q();
    fd0 = fd_cnt;
    for (int i = 0; i < 48; i++) begin
      send(i, 1'b1);
      if (i == 18) begin
        check("s3_hold_valid", 72'(bus.out_valid), 72'(1));
        held          = bus.out_window;
        bus.out_ready = 1'b0;
        bus.in_pixel  = 8'(19);
        repeat (5) begin
          @(negedge clk);
          check("s3_in_ready_low", 72'(bus.in_ready),  72'(0));
          check("s3_valid_held",   72'(bus.out_valid), 72'(1));
          check("s3_window_held",  bus.out_window,     held);
        end
        @(posedge clk);
        #1;
      end
    end
    drain();
    check("s3_count", 72'(q_win.size()), 72'(24));
    check_frame(0, 0, "s3");
    check("s3_fd_count", 72'(fd_cnt), 72'(fd0 + 1));

    // Two frames back to back, second frame offset by 100
    clear_q();
    fd0 = fd_cnt;
    for (int i = 0; i < 48; i++) send(i, 1'b0);
    for (int i = 0; i < 48; i++) send(100 + i, 1'b0);
    drain();
    check("s4_count", 72'(q_win.size()), 72'(48));
    if (q_win.size() >= 25)
      check("s4_f2_first", q_win[24], 72'h646566_6C6D6E_747576);
    check_frame(0, 0, "s4a");
    check_frame(24, 100, "s4b");
    check("s4_fd_count", 72'(fd_cnt), 72'(fd0 + 2));

    // Reset in the middle of a frame
    for (int i = 0; i <= 20; i++) send(i, 1'b0);
    check("s5_valid_before", 72'(bus.out_valid), 72'(1));
    bus.in_valid = 1'b0;
    reset_n      = 1'b0;
    #1;
    check("s5_valid_dropped", 72'(bus.out_valid), 72'(0));
    check("s5_col_cleared",   72'(bus.out_col),   72'(0));
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    clear_q();
    for (int i = 0; i < 48; i++) send(i, 1'b0);
    drain();
    check("s5_count", 72'(q_win.size()), 72'(24));
    check_frame(0, 0, "s5");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
